// File: rtl/sec_timer.sv
// Purpose: OS seconds timer. Turns the 1 s square wave into clk-domain ticks and keeps uptime. Runs a countdown with a sticky irq.
// Latency: tick_pulse is high in the 3rd cycle after tick_in is first sampled high; count, irq and uptime update one cycle after tick_pulse.
// Backpressure: none. Strobes are consumed in the cycle they are sampled, and irq/overrun hold until irq_ack.
module sec_timer #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic             tick_pulse,
  output logic [31:0]      uptime,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             irq,
  output logic             overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;    // marks which sync stages hold real samples since reset
  logic                   s;
  logic                   s_vld;
  logic                   s_d;
  logic                   primed;
  logic [31:0]            uptime_q;
  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       count_q, count_n;
  logic [CNT_W-1:0]       reload_q, reload_n;
  logic                   irq_q, irq_n;
  logic                   ovr_q, ovr_n;

  assign s     = sync_q[SYNC_STAGES-1];
  assign s_vld = vld_q[SYNC_STAGES-1];

  // Synchronise tick_in and track when the chain output is a genuine sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge detect; primed waits for a real low sample, so a level that is already high at reset release never counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d        <= 1'b0;
      primed     <= 1'b0;
      tick_pulse <= 1'b0;
      uptime_q   <= '0;
    end else begin
      s_d        <= s;
      primed     <= primed | (s_vld & ~s);
      tick_pulse <= primed & s & ~s_d;
      if (tick_pulse) uptime_q <= uptime_q + 32'd1;
    end
  end

  // Countdown state and sticky interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      irq_q    <= irq_n;
      ovr_q    <= ovr_n;
    end
  end

  // Next state: load beats enable beats tick. An expiry sets irq even when an ack arrives in the same cycle.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    irq_n    = irq_q & ~irq_ack;
    ovr_n    = ovr_q & ~irq_ack;
    case (state_q)
      IDLE: begin
        if (load) begin
          count_n  = load_val;
          reload_n = load_val;
        end else if (enable && count_q != '0) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (load) begin
          count_n  = load_val;
          reload_n = load_val;
          if (load_val == '0) state_n = IDLE;
        end else if (!enable) begin
          state_n = IDLE;
        end else if (tick_pulse) begin
          if (count_q > CNT_W'(1)) begin
            count_n = count_q - CNT_W'(1);
          end else if (count_q == CNT_W'(1)) begin
            irq_n = 1'b1;
            if (irq_q) ovr_n = 1'b1;
            if (periodic && reload_q != '0) begin
              count_n = reload_q;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign uptime  = uptime_q;
  assign count   = count_q;
  assign running = (state_q == RUN);
  assign irq     = irq_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sec_timer.sv
module tb_sec_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        load;
  logic [15:0] load_val;
  logic        enable;
  logic        periodic;
  logic        irq_ack;
  logic        tick_pulse;
  logic [31:0] uptime;
  logic [15:0] count;
  logic        running;
  logic        irq;
  logic        overrun;

  sec_timer #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .load       (load),
    .load_val   (load_val),
    .enable     (enable),
    .periodic   (periodic),
    .irq_ack    (irq_ack),
    .tick_pulse (tick_pulse),
    .uptime     (uptime),
    .count      (count),
    .running    (running),
    .irq        (irq),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] up;
    logic [15:0] cnt;
    logic        run;
    logic        irq;
    logic        ovr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_up;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One tick_in period (4 high, 4 low). Expected post-tick state goes to the scoreboard; optional load/ack strobe lands on the tick_pulse cycle.
  task automatic do_tick(input logic [15:0] cnt, input logic run, input logic ir, input logic ov,
                         input bit ld, input bit ak);
    exp_t e;
    int   seen;
    exp_up = exp_up + 32'd1;
    e.up = exp_up; e.cnt = cnt; e.run = run; e.irq = ir; e.ovr = ov;
    sb.push_back(e);
    seen = -1;
    tick_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load    = 1'b0;
      irq_ack = 1'b0;
      if (tick_pulse === 1'b1 && seen < 0) begin
        seen    = i;
        load    = ld;
        irq_ack = ak;
      end
    end
    load    = 1'b0;
    irq_ack = 1'b0;
    chk("tick_latency", seen + 1, 3);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard side: each tick_pulse pops one expectation and compares one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          @(negedge clk);
          chk("pulse_width", tick_pulse, 0);
          chk("uptime", uptime, mon_e.up);
          chk("count", count, mon_e.cnt);
          chk("running", running, mon_e.run);
          chk("irq", irq, mon_e.irq);
          chk("overrun", overrun, mon_e.ovr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_in = 1'b1; load = 1'b0; load_val = '0;
    enable = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
    exp_up = '0;
    repeat (3) @(negedge clk);
    chk("rst_uptime", uptime, 0);
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pulse", tick_pulse, 0);

    // tick_in high through reset release: no pulse until it drops and rises again
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_high_uptime", uptime, 0);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    do_tick(16'd0, 1'b0, 1'b0, 1'b0, 0, 0);

    // IDLE ignores ticks for the countdown
    do_load(16'd9);
    chk("idle_load_count", count, 9);
    chk("idle_load_running", running, 0);
    for (int i = 0; i < 5; i++) do_tick(16'd9, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("uptime_after_5", uptime, 6);

    // one-shot
    periodic = 1'b0;
    enable   = 1'b1;
    do_load(16'd3);
    chk("oneshot_running", running, 1);
    chk("oneshot_count", count, 3);
    do_tick(16'd2, 1'b1, 1'b0, 1'b0, 0, 0);
    do_tick(16'd1, 1'b1, 1'b0, 1'b0, 0, 0);
    do_tick(16'd0, 1'b0, 1'b1, 1'b0, 0, 0);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("oneshot_ack_irq", irq, 0);

    // periodic, no ack: second expiry raises overrun
    periodic = 1'b1;
    do_load(16'd2);
    chk("periodic_running", running, 1);
    do_tick(16'd1, 1'b1, 1'b0, 1'b0, 0, 0);
    do_tick(16'd2, 1'b1, 1'b1, 1'b0, 0, 0);
    do_tick(16'd1, 1'b1, 1'b1, 1'b0, 0, 0);
    do_tick(16'd2, 1'b1, 1'b1, 1'b1, 0, 0);
    do_tick(16'd1, 1'b1, 1'b1, 1'b1, 0, 0);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("periodic_ack_irq", irq, 0);
    chk("periodic_ack_ovr", overrun, 0);

    // pause, then load coincident with a tick
    do_load(16'd5);
    chk("pause_count", count, 5);
    enable = 1'b0;
    @(negedge clk);
    chk("pause_running", running, 0);
    do_tick(16'd5, 1'b0, 1'b0, 1'b0, 0, 0);
    do_tick(16'd5, 1'b0, 1'b0, 1'b0, 0, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume_running", running, 1);
    load_val = 16'd7;
    do_tick(16'd7, 1'b1, 1'b0, 1'b0, 1, 0);

    // ack coincident with periodic expiry: first with irq clear, then with irq set
    do_load(16'd1);
    do_tick(16'd1, 1'b1, 1'b1, 1'b0, 0, 1);
    do_tick(16'd1, 1'b1, 1'b1, 1'b1, 0, 1);

    // reset in the middle of a countdown
    do_load(16'd3);
    do_tick(16'd2, 1'b1, 1'b1, 1'b1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_running", running, 0);
    chk("midrst_irq", irq, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_uptime", uptime, 0);
    exp_up = '0;
    repeat (4) @(negedge clk);

    // uptime wrap
    force dut.uptime_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.uptime_q;
    @(negedge clk);
    chk("preset_uptime", uptime, 32'hFFFF_FFFF);
    exp_up = 32'hFFFF_FFFF;
    do_tick(16'd0, 1'b0, 1'b0, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
